// File: rtl/shift_reg_univ.sv
// Universal shift register: shift-up, shift-down and parallel load, with a count of valid stages.
// Optional define SHIFT_REG_UNIV_PARITY_EN adds o_parity, the XOR of all stored bits.
module shift_reg_univ #(
  parameter int WIDTH  = 1,
  parameter int LENGTH = 8,
  localparam int CNT_W = $clog2(LENGTH + 1),
  localparam int PW    = LENGTH * WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_din,
  input  logic [PW-1:0]    i_pdin,
  output logic [WIDTH-1:0] o_dout,
  output logic [PW-1:0]    o_pdout,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full
`ifdef SHIFT_REG_UNIV_PARITY_EN
  ,
  output logic             o_parity
`endif
);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LENGTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_FULL) ? c : c + CNT_ONE;
  endfunction

  logic [PW-1:0]    stage_p1, stage_nxt;
  logic [CNT_W-1:0] count_p1, count_nxt;
  logic             full_p1, full_nxt;
  logic             dir_up_p1, dir_up_nxt;
  // A reversal only invalidates older words if they were entered by a shift;
  // after reset or a parallel load every stage is already accounted for.
  logic             shifted_p1, shifted_nxt;

  always_comb begin
    stage_nxt   = stage_p1;
    count_nxt   = count_p1;
    dir_up_nxt  = dir_up_p1;
    shifted_nxt = shifted_p1;
    if (i_en) begin
      case (i_mode)
        MODE_UP: begin
          stage_nxt   = {stage_p1[PW-WIDTH-1:0], i_din};
          count_nxt   = (shifted_p1 && !dir_up_p1) ? CNT_ONE : sat_inc(count_p1);
          dir_up_nxt  = 1'b1;
          shifted_nxt = 1'b1;
        end
        MODE_DOWN: begin
          stage_nxt   = {i_din, stage_p1[PW-1:WIDTH]};
          count_nxt   = (shifted_p1 && dir_up_p1) ? CNT_ONE : sat_inc(count_p1);
          dir_up_nxt  = 1'b0;
          shifted_nxt = 1'b1;
        end
        MODE_LOAD: begin
          stage_nxt   = i_pdin;
          count_nxt   = CNT_FULL;
          shifted_nxt = 1'b0;
        end
        MODE_HOLD: ;
        default: ;
      endcase
    end
    full_nxt = (count_nxt == CNT_FULL);
  end

  // ---- stage p1: registered state ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stage_p1   <= '0;
      count_p1   <= '0;
      full_p1    <= 1'b0;
      dir_up_p1  <= 1'b1;
      shifted_p1 <= 1'b0;
    end else begin
      stage_p1   <= stage_nxt;
      count_p1   <= count_nxt;
      full_p1    <= full_nxt;
      dir_up_p1  <= dir_up_nxt;
      shifted_p1 <= shifted_nxt;
    end
  end

  assign o_pdout = stage_p1;
  assign o_count = count_p1;
  assign o_full  = full_p1;
  assign o_dout  = dir_up_p1 ? stage_p1[PW-WIDTH +: WIDTH] : stage_p1[0 +: WIDTH];

`ifdef SHIFT_REG_UNIV_PARITY_EN
  assign o_parity = ^stage_p1;
`endif

endmodule

// File: tb/tb_shift_reg_univ.sv
// Bench for shift_reg_univ: scoreboard on a WIDTH=1/LENGTH=8 instance plus a 4x4 instance.
module tb_shift_reg_univ;
  localparam int W = 1;
  localparam int L = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0, en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       din = 1'b0;
  logic [7:0] pdin = 8'h00;
  logic       dout;
  logic [7:0] pdout;
  logic [3:0] count;
  logic       full;

  logic        rst2 = 1'b0, en2 = 1'b0;
  logic [1:0]  mode2 = 2'b00;
  logic [3:0]  din2 = 4'h0;
  logic [15:0] pdin2 = 16'h0;
  logic [3:0]  dout2;
  logic [15:0] pdout2;
  logic [2:0]  count2;
  logic        full2;

`ifdef SHIFT_REG_UNIV_PARITY_EN
  logic parity, parity2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_reg_univ #(.WIDTH(W), .LENGTH(L)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_din(din), .i_pdin(pdin),
    .o_dout(dout), .o_pdout(pdout), .o_count(count), .o_full(full)
`ifdef SHIFT_REG_UNIV_PARITY_EN
    , .o_parity(parity)
`endif
  );

  shift_reg_univ #(.WIDTH(4), .LENGTH(4)) dut2 (
    .i_clk(clk), .i_rst(rst2), .i_en(en2), .i_mode(mode2), .i_din(din2), .i_pdin(pdin2),
    .o_dout(dout2), .o_pdout(pdout2), .o_count(count2), .o_full(full2)
`ifdef SHIFT_REG_UNIV_PARITY_EN
    , .o_parity(parity2)
`endif
  );

  typedef struct {
    logic [7:0] pdout;
    logic [3:0] count;
    logic       full;
    logic       dout;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  // Reference model state
  logic m_stg [L];
  bit   m_up = 1'b1;
  bit   m_shifted = 1'b0;
  int   m_cnt = 0;

  task automatic cycle(input logic r, input logic e, input logic [1:0] md,
                       input logic d, input logic [7:0] pd);
    exp_t x;
    if (r) begin
      for (int k = 0; k < L; k++) m_stg[k] = 1'b0;
      m_cnt = 0; m_up = 1'b1; m_shifted = 1'b0;
    end else if (e) begin
      case (md)
        2'b01: begin
          for (int k = L - 1; k > 0; k--) m_stg[k] = m_stg[k-1];
          m_stg[0] = d;
          if (m_shifted && !m_up) m_cnt = 1;
          else if (m_cnt < L) m_cnt = m_cnt + 1;
          m_up = 1'b1; m_shifted = 1'b1;
        end
        2'b10: begin
          for (int k = 0; k < L - 1; k++) m_stg[k] = m_stg[k+1];
          m_stg[L-1] = d;
          if (m_shifted && m_up) m_cnt = 1;
          else if (m_cnt < L) m_cnt = m_cnt + 1;
          m_up = 1'b0; m_shifted = 1'b1;
        end
        2'b11: begin
          for (int k = 0; k < L; k++) m_stg[k] = pd[k];
          m_cnt = L; m_shifted = 1'b0;
        end
        default: ;
      endcase
    end
    for (int k = 0; k < L; k++) x.pdout[k] = m_stg[k];
    x.count = 4'(m_cnt);
    x.full  = (m_cnt == L);
    x.dout  = m_up ? m_stg[L-1] : m_stg[0];
    rst = r; en = e; mode = md; din = d; pdin = pd;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: one expectation retired per clock edge.
  always @(posedge clk) begin
    #2;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      checks++;
      if (pdout !== mon_e.pdout) begin
        errors++; $display("FAIL sb_pdout got %h expected %h at %0t", pdout, mon_e.pdout, $time);
      end
      checks++;
      if (count !== mon_e.count) begin
        errors++; $display("FAIL sb_count got %0d expected %0d at %0t", count, mon_e.count, $time);
      end
      checks++;
      if (full !== mon_e.full) begin
        errors++; $display("FAIL sb_full got %b expected %b at %0t", full, mon_e.full, $time);
      end
      checks++;
      if (dout !== mon_e.dout) begin
        errors++; $display("FAIL sb_dout got %b expected %b at %0t", dout, mon_e.dout, $time);
      end
`ifdef SHIFT_REG_UNIV_PARITY_EN
      checks++;
      if (parity !== ^mon_e.pdout) begin
        errors++; $display("FAIL sb_parity got %b expected %b at %0t", parity, ^mon_e.pdout, $time);
      end
`endif
    end
  end

  task automatic test_reset();
    cycle(1'b1, 1'b1, 2'b11, 1'b1, 8'hFF);
    checks++;
    if (pdout !== 8'h00 || count !== 4'd0 || full !== 1'b0 || dout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got pdout=%h count=%0d full=%b dout=%b expected 00/0/0/0", pdout, count, full, dout);
    end
  endtask

  task automatic test_shift_up_a5();
    logic [7:0] pat;
    pat = 8'hA5;
    cycle(1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 2'b01, pat[i], 8'h00);
    checks++;
    if (pdout !== 8'hA5 || count !== 4'd8 || full !== 1'b1 || dout !== 1'b1) begin
      errors++;
      $display("FAIL shift_up_a5 got pdout=%h count=%0d full=%b dout=%b expected a5/8/1/1", pdout, count, full, dout);
    end
  endtask

  task automatic test_saturate();
    logic [9:0] pat;
    logic [7:0] want;
    pat = 10'b11_0100_1110;
    cycle(1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, 2'b01, pat[i], 8'h00);
      if (i >= 7) begin
        checks++;
        if (count !== 4'd8 || full !== 1'b1) begin
          errors++;
          $display("FAIL saturate_cycle%0d got count=%0d full=%b expected 8/1", i, count, full);
        end
      end
    end
    for (int k = 0; k < 8; k++) want[k] = pat[9 - k];
    checks++;
    if (pdout !== want) begin
      errors++; $display("FAIL saturate_pdout got %h expected %h", pdout, want);
    end
  endtask

  task automatic test_load_shift_down();
    cycle(1'b0, 1'b1, 2'b11, 1'b0, 8'h3C);
    checks++;
    if (pdout !== 8'h3C || count !== 4'd8) begin
      errors++; $display("FAIL load_3c got pdout=%h count=%0d expected 3c/8", pdout, count);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 2'b10, 1'b1, 8'h00);
    checks++;
    if (pdout !== 8'hE7 || count !== 4'd8 || dout !== 1'b1) begin
      errors++; $display("FAIL shift_down_e7 got pdout=%h count=%0d dout=%b expected e7/8/1", pdout, count, dout);
    end
  endtask

  task automatic test_reversal();
    cycle(1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 2'b01, 1'b1, 8'h00);
    cycle(1'b0, 1'b1, 2'b01, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 2'b01, 1'b1, 8'h00);
    checks++;
    if (count !== 4'd3) begin
      errors++; $display("FAIL pre_reversal_count got %0d expected 3", count);
    end
    cycle(1'b0, 1'b1, 2'b10, 1'b1, 8'h00);
    checks++;
    if (count !== 4'd1 || full !== 1'b0) begin
      errors++; $display("FAIL reversal_up_down got count=%0d full=%b expected 1/0", count, full);
    end
    cycle(1'b0, 1'b1, 2'b10, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 2'b01, 1'b0, 8'h00);
    checks++;
    if (count !== 4'd1) begin
      errors++; $display("FAIL reversal_down_up got count=%0d expected 1", count);
    end
  endtask

  task automatic test_reset_priority();
    cycle(1'b0, 1'b1, 2'b11, 1'b0, 8'hFF);
    cycle(1'b1, 1'b1, 2'b01, 1'b1, 8'h00);
    checks++;
    if (pdout !== 8'h00 || count !== 4'd0 || dout !== 1'b0) begin
      errors++; $display("FAIL reset_over_shift got pdout=%h count=%0d dout=%b expected 00/0/0", pdout, count, dout);
    end
    cycle(1'b0, 1'b1, 2'b01, 1'b1, 8'h00);
    cycle(1'b1, 1'b1, 2'b11, 1'b1, 8'hAA);
    checks++;
    if (pdout !== 8'h00 || count !== 4'd0) begin
      errors++; $display("FAIL reset_over_load got pdout=%h count=%0d expected 00/0", pdout, count);
    end
    cycle(1'b0, 1'b1, 2'b11, 1'b0, 8'h5A);
    cycle(1'b0, 1'b1, 2'b10, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 2'(i % 4), 1'b1, 8'hC3);
    cycle(1'b0, 1'b1, 2'b00, 1'b0, 8'h0F);
    checks++;
    if (pdout !== 8'hAD || count !== 4'd8 || dout !== 1'b1) begin
      errors++; $display("FAIL enable_low_hold got pdout=%h count=%0d dout=%b expected ad/8/1", pdout, count, dout);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++)
      cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
  endtask

  task automatic test_wide();
    rst2 = 1'b1; en2 = 1'b0;
    @(posedge clk); #1;
    rst2 = 1'b0; en2 = 1'b1; mode2 = 2'b11; pdin2 = 16'h1234;
    @(posedge clk); #1;
    checks++;
    if (pdout2 !== 16'h1234 || count2 !== 3'd4 || full2 !== 1'b1) begin
      errors++; $display("FAIL wide_load got pdout=%h count=%0d full=%b expected 1234/4/1", pdout2, count2, full2);
    end
`ifdef SHIFT_REG_UNIV_PARITY_EN
    checks++;
    if (parity2 !== 1'b1) begin
      errors++; $display("FAIL wide_parity_load got %b expected 1", parity2);
    end
`endif
    mode2 = 2'b01; din2 = 4'hF;
    @(posedge clk); #1;
    en2 = 1'b0;
    checks++;
    if (pdout2 !== 16'h234F || dout2 !== 4'h2 || count2 !== 3'd4) begin
      errors++; $display("FAIL wide_shift got pdout=%h dout=%h count=%0d expected 234f/2/4", pdout2, dout2, count2);
    end
`ifdef SHIFT_REG_UNIV_PARITY_EN
    checks++;
    if (parity2 !== 1'b0) begin
      errors++; $display("FAIL wide_parity_shift got %b expected 0", parity2);
    end
`endif
  endtask

  initial begin
    for (int k = 0; k < L; k++) m_stg[k] = 1'b0;
    @(negedge clk);
    test_reset();
    test_shift_up_a5();
    test_saturate();
    test_load_shift_down();
    test_reversal();
    test_reset_priority();
    test_back_to_back();
    test_wide();
    @(posedge clk); #3;
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
